// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: memory opcode encoding and fixed request fields.
package fetch_unit_pkg;

   typedef enum logic {
      MemOpRead  = 1'b0,
      MemOpWrite = 1'b1
   } mem_op_e;

   localparam mem_op_e     MEM_OP_READ  = MemOpRead;
   localparam logic [1:0]  MEM_LEN_WORD = 2'd0;
   localparam int unsigned INST_BYTES   = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: memory request/response channels plus the F->D handoff and redirect.
// Message structs live here because they are sized by the interface parameters.
interface fetch_unit_if #(
   parameter int unsigned p_addr_bits = 32,
   parameter int unsigned p_inst_bits = 32,
   parameter int unsigned p_opaq_bits = 8
);
   import fetch_unit_pkg::*;

   typedef struct packed {
      mem_op_e                op;
      logic [p_opaq_bits-1:0] opaque;
      logic [p_addr_bits-1:0] addr;
      logic [1:0]             len;
      logic [p_inst_bits-1:0] data;
   } mem_req_t;

   typedef struct packed {
      logic [p_opaq_bits-1:0] opaque;
      logic [p_addr_bits-1:0] addr;
      logic [p_inst_bits-1:0] data;
   } mem_resp_t;

   logic                   mem_req_val;
   logic                   mem_req_rdy;
   mem_req_t               mem_req;
   logic                   mem_resp_val;
   logic                   mem_resp_rdy;
   mem_resp_t              mem_resp;
   logic                   d_val;
   logic                   d_rdy;
   logic [p_inst_bits-1:0] d_inst;
   logic [p_addr_bits-1:0] d_pc;
   logic                   d_squash;
   logic [p_addr_bits-1:0] d_branch_target;

   modport master (
      output mem_req_val, mem_req, mem_resp_rdy, d_val, d_inst, d_pc,
      input  mem_req_rdy, mem_resp_val, mem_resp, d_rdy, d_squash, d_branch_target
   );

   modport slave (
      input  mem_req_val, mem_req, mem_resp_rdy, d_val, d_inst, d_pc,
      output mem_req_rdy, mem_resp_val, mem_resp, d_rdy, d_squash, d_branch_target
   );

endinterface

// File: rtl/fetch_pc_gen.sv
// PC and fetch-epoch registers: sequential word increment on an accepted request, redirect on
// squash (which also opens a new epoch).
module fetch_pc_gen
   import fetch_unit_pkg::*;
#(
   parameter int unsigned            p_addr_bits = 32,
   parameter int unsigned            p_opaq_bits = 8,
   parameter logic [p_addr_bits-1:0] p_rst_addr  = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_fire_i,
   input  logic                   squash_i,
   input  logic [p_addr_bits-1:0] target_i,
   output logic [p_addr_bits-1:0] pc_o,
   output logic [p_opaq_bits-1:0] epoch_o
);

   logic [p_addr_bits-1:0] pc_q, pc_d;
   logic [p_opaq_bits-1:0] epoch_q, epoch_d;

   always_comb begin
      pc_d    = pc_q;
      epoch_d = epoch_q;
      // Redirect wins over the sequential step.
      if (squash_i) begin
         pc_d    = target_i;
         epoch_d = epoch_q + p_opaq_bits'(1);
      end else if (req_fire_i) begin
         pc_d = pc_q + p_addr_bits'(INST_BYTES);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q    <= p_rst_addr;
         epoch_q <= '0;
      end else begin
         pc_q    <= pc_d;
         epoch_q <= epoch_d;
      end
   end

   assign pc_o    = pc_q;
   assign epoch_o = epoch_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams word reads from pc and forwards epoch-matching responses to
// decode with no added latency. Define FETCH_TRACE_EN for a simulation-only line trace.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned            p_addr_bits = 32,
   parameter int unsigned            p_inst_bits = 32,
   parameter int unsigned            p_opaq_bits = 8,
   parameter logic [p_addr_bits-1:0] p_rst_addr  = '0
) (
   input logic          clk_i,
   input logic          rst_ni,
   fetch_unit_if.master bus
);

   logic [p_addr_bits-1:0] pc;
   logic [p_opaq_bits-1:0] epoch;
   logic                   live;

   fetch_pc_gen #(
      .p_addr_bits(p_addr_bits),
      .p_opaq_bits(p_opaq_bits),
      .p_rst_addr (p_rst_addr)
   ) u_pc_gen (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_fire_i(bus.mem_req_val && bus.mem_req_rdy),
      .squash_i  (bus.d_squash),
      .target_i  (bus.d_branch_target),
      .pc_o      (pc),
      .epoch_o   (epoch)
   );

   // A response in a squash cycle is still judged against the pre-squash epoch.
   assign live = (bus.mem_resp.opaque == epoch);

   always_comb begin
      bus.mem_req_val = rst_ni && !bus.d_squash;
      bus.mem_req     = '{op: MEM_OP_READ, opaque: epoch, addr: pc, len: MEM_LEN_WORD, data: '0};
      // Stale responses are always accepted so they drain even while decode stalls.
      bus.mem_resp_rdy = rst_ni && (!live || bus.d_rdy);
      bus.d_val        = rst_ni && bus.mem_resp_val && live;
      bus.d_inst       = bus.mem_resp.data;
      bus.d_pc         = bus.mem_resp.addr;
   end

`ifdef FETCH_TRACE_EN
   string trace_str;

   always_comb begin
      trace_str = $sformatf("F req:%s %h/%h | resp:%s | D:%s %h@%h",
                            (bus.mem_req_val && bus.mem_req_rdy) ? "fire" : " -- ",
                            pc, epoch,
                            !bus.mem_resp_val ? "none" : (live ? "live" : "drop"),
                            (bus.d_val && bus.d_rdy) ? "xfer" : " -- ",
                            bus.d_inst, bus.d_pc);
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three configurations driven by a latency-randomising memory and a
// decode that redirects per a branch table; delivered stream checked against program order.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_rdy, resp_val, d_rdy, squash;
   logic [31:0] resp_addr, resp_data, br_tgt;
   logic [7:0]  resp_opq;
   int unsigned cfg;

   fetch_unit_if #(.p_addr_bits(32), .p_inst_bits(32), .p_opaq_bits(8)) bus_a ();
   fetch_unit_if #(.p_addr_bits(32), .p_inst_bits(32), .p_opaq_bits(8)) bus_b ();
   fetch_unit_if #(.p_addr_bits(8), .p_inst_bits(8), .p_opaq_bits(1)) bus_c ();

   fetch_unit #(.p_addr_bits(32), .p_inst_bits(32), .p_opaq_bits(8), .p_rst_addr(32'h0))
      dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
   fetch_unit #(.p_addr_bits(32), .p_inst_bits(32), .p_opaq_bits(8),
                .p_rst_addr(32'h00FF_FF00))
      dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));
   fetch_unit #(.p_addr_bits(8), .p_inst_bits(8), .p_opaq_bits(1), .p_rst_addr(8'hF0))
      dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(bus_c));

   assign bus_a.mem_req_rdy     = req_rdy;
   assign bus_a.mem_resp_val    = resp_val;
   assign bus_a.mem_resp        = '{opaque: resp_opq, addr: resp_addr, data: resp_data};
   assign bus_a.d_rdy           = d_rdy;
   assign bus_a.d_squash        = squash;
   assign bus_a.d_branch_target = br_tgt;
   assign bus_b.mem_req_rdy     = req_rdy;
   assign bus_b.mem_resp_val    = resp_val;
   assign bus_b.mem_resp        = '{opaque: resp_opq, addr: resp_addr, data: resp_data};
   assign bus_b.d_rdy           = d_rdy;
   assign bus_b.d_squash        = squash;
   assign bus_b.d_branch_target = br_tgt;
   assign bus_c.mem_req_rdy     = req_rdy;
   assign bus_c.mem_resp_val    = resp_val;
   assign bus_c.mem_resp        = '{opaque: resp_opq[0], addr: resp_addr[7:0],
                                    data: resp_data[7:0]};
   assign bus_c.d_rdy           = d_rdy;
   assign bus_c.d_squash        = squash;
   assign bus_c.d_branch_target = br_tgt[7:0];

   logic        o_req_val, o_resp_rdy, o_d_val;
   logic [31:0] o_req_addr, o_req_misc, o_d_inst, o_d_pc;
   logic [7:0]  o_req_opq;

   always_comb begin
      case (cfg)
         0: begin
            o_req_val  = bus_a.mem_req_val;
            o_req_addr = bus_a.mem_req.addr;
            o_req_opq  = bus_a.mem_req.opaque;
            o_req_misc = 32'(bus_a.mem_req.op) | 32'(bus_a.mem_req.len) | bus_a.mem_req.data;
            o_resp_rdy = bus_a.mem_resp_rdy;
            o_d_val    = bus_a.d_val;
            o_d_inst   = bus_a.d_inst;
            o_d_pc     = bus_a.d_pc;
         end
         1: begin
            o_req_val  = bus_b.mem_req_val;
            o_req_addr = bus_b.mem_req.addr;
            o_req_opq  = bus_b.mem_req.opaque;
            o_req_misc = 32'(bus_b.mem_req.op) | 32'(bus_b.mem_req.len) | bus_b.mem_req.data;
            o_resp_rdy = bus_b.mem_resp_rdy;
            o_d_val    = bus_b.d_val;
            o_d_inst   = bus_b.d_inst;
            o_d_pc     = bus_b.d_pc;
         end
         default: begin
            o_req_val  = bus_c.mem_req_val;
            o_req_addr = 32'(bus_c.mem_req.addr);
            o_req_opq  = 8'(bus_c.mem_req.opaque);
            o_req_misc = 32'(bus_c.mem_req.op) | 32'(bus_c.mem_req.len) |
                         32'(bus_c.mem_req.data);
            o_resp_rdy = bus_c.mem_resp_rdy;
            o_d_val    = bus_c.d_val;
            o_d_inst   = 32'(bus_c.d_inst);
            o_d_pc     = 32'(bus_c.d_pc);
         end
      endcase
   end

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  opq;
      int unsigned ready_at;
   } inflight_t;

   inflight_t   q[$];
   logic [31:0] mem[logic [31:0]];
   int unsigned br_idx[$];
   logic [31:0] br_off[$];

   int unsigned n_assert, n_fail, cyc, last_ready, n_dlv;
   logic [31:0] rst_addr, amask, imask, omask;
   logic [31:0] m_pc, m_epoch, exp_pc, sq_tgt;
   logic        sq_pend;
   bit          bp;
   int unsigned dly;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return (mem.exists(a) ? mem[a] : {a[15:0] ^ 16'hA5C3, a[15:0]}) & imask;
   endfunction

   task automatic put(input logic [31:0] off, input logic [31:0] d);
      mem[(rst_addr + off) & amask] = d;
   endtask

   task automatic set_cfg(input int unsigned c);
      cfg = c;
      case (c)
         0:       begin rst_addr = 32'h0;        amask = '1;     imask = '1;     omask = 32'hFF; end
         1:       begin rst_addr = 32'h00FF_FF00; amask = '1;    imask = '1;     omask = 32'hFF; end
         default: begin rst_addr = 32'hF0;       amask = 32'hFF; imask = 32'hFF; omask = 32'h1;  end
      endcase
   endtask

   task automatic init_model();
      q.delete();
      m_pc = rst_addr; m_epoch = 0; exp_pc = rst_addr;
      n_dlv = 0; last_ready = 0; sq_pend = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_rdy = 1'b0; resp_val = 1'b0; d_rdy = 1'b0; squash = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      init_model();
      @(posedge clk) #1;
   endtask

   // One clock: drive memory/decode behaviour, check outputs, advance the reference model.
   task automatic cycle(input bit bpress, input int unsigned max_dly);
      logic        live, fire, pop, dlv;
      int unsigned ready;
      squash  = sq_pend; br_tgt = sq_tgt; sq_pend = 1'b0;
      req_rdy = (max_dly == 0) || ($urandom_range(0, 3) != 0);
      d_rdy   = !squash && (!bpress || (cyc % 4 == 0));
      if (q.size() != 0 && q[0].ready_at <= cyc) begin
         resp_val = 1'b1; resp_addr = q[0].addr; resp_opq = q[0].opq; resp_data = rd(q[0].addr);
      end else begin
         resp_val = 1'b0; resp_addr = $urandom; resp_opq = 8'($urandom); resp_data = $urandom;
      end
      #1;
      live = ((32'(resp_opq) & omask) == m_epoch);
      fire = !squash && req_rdy;
      pop  = resp_val && (!live || d_rdy);
      dlv  = resp_val && live && d_rdy;
      chk(32'(o_req_val), 32'(!squash), "req_val");
      if (!squash) begin
         chk(o_req_addr, m_pc, "req_addr");
         chk(32'(o_req_opq), m_epoch, "req_opaque");
         chk(o_req_misc, 32'h0, "req_fixed_fields");
      end
      chk(32'(o_d_val), 32'(resp_val && live), "d_val");
      chk(32'(o_resp_rdy), 32'(!live || d_rdy), "resp_rdy");
      if (dlv) begin
         chk(o_d_pc, exp_pc, "d_pc");
         chk(o_d_inst, rd(exp_pc), "d_inst");
         exp_pc = (exp_pc + 4) & amask;
         for (int i = 0; i < br_idx.size(); i++) begin
            if (br_idx[i] == n_dlv && !sq_pend) begin
               sq_pend = 1'b1;
               sq_tgt  = (rst_addr + br_off[i]) & amask;
               exp_pc  = sq_tgt;
            end
         end
         n_dlv++;
      end
      if (pop) void'(q.pop_front());
      if (fire) begin
         ready = cyc + 1 + $urandom_range(0, max_dly);
         if (ready < last_ready) ready = last_ready;
         last_ready = ready;
         q.push_back('{o_req_addr, o_req_opq, ready});
      end
      if (squash) begin
         m_pc    = br_tgt & amask;
         m_epoch = (m_epoch + 1) & omask;
      end else if (fire) begin
         m_pc = (m_pc + 4) & amask;
      end
      cyc++;
      @(posedge clk) #1;
   endtask

   task automatic run_until(input int unsigned nexp, input bit bpress, input int unsigned max_dly);
      int unsigned budget = 0;
      while (n_dlv < nexp && budget < 2000) begin
         cycle(bpress, max_dly);
         budget++;
      end
      chk(n_dlv, nexp, "delivery_count");
   endtask

   task automatic load_seq();
      mem.delete(); br_idx.delete(); br_off.delete();
      put(32'h0, 32'hDEAD_BEEF); put(32'h4, 32'hCAFE_F00D); put(32'h8, 32'hBAAD_B0BA);
   endtask

   task automatic load_back();
      mem.delete();
      put(32'h0, 32'hDEAD_BEEF); put(32'h4, 32'hFEDC_BA00); put(32'h8, 32'h1234_5678);
      br_idx = '{1, 4};
      br_off = '{32'h0, 32'h4};
   endtask

   task automatic load_fwd();
      mem.delete();
      put(32'h00, 32'h1010_1010); put(32'h04, 32'h2020_2020); put(32'h10, 32'h3030_3030);
      put(32'h14, 32'h4040_4040); put(32'h48, 32'h5050_5050); put(32'h4C, 32'h6060_6060);
      br_idx = '{1, 3};
      br_off = '{32'h10, 32'h48};
   endtask

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0; cfg = 0;
      resp_addr = '0; resp_data = '0; resp_opq = '0; br_tgt = '0; sq_tgt = '0;
      set_cfg(0);
      init_model();

      for (int c = 0; c < 3; c++) begin
         set_cfg(c);
         bp  = (c != 0);
         dly = (c != 0) ? 3 : 0;
         load_seq();  do_reset(); run_until(3, bp, dly);
         load_back(); do_reset(); run_until(7, bp, dly);
         load_fwd();  do_reset(); run_until(6, bp, dly);
      end

      // Random branches and latencies over the default-data memory.
      set_cfg(0);
      mem.delete(); br_idx.delete(); br_off.delete();
      for (int i = 0; i < 8; i++) begin
         br_idx.push_back($urandom_range(0, 39));
         br_off.push_back(32'($urandom_range(0, 255)) * 4);
      end
      do_reset(); run_until(40, 1'b1, 3);

      // Asynchronous reset in the middle of a redirected stream.
      set_cfg(1);
      load_fwd(); do_reset(); run_until(6, 1'b0, 0);
      cycle(1'b0, 0); cycle(1'b0, 0);
      rst_n = 1'b0; squash = 1'b0; req_rdy = 1'b1; d_rdy = 1'b1;
      resp_val = 1'b1; resp_opq = 8'h0; resp_addr = rst_addr; resp_data = 32'h0BAD_0BAD;
      #1;
      chk(32'(o_req_val), 32'h0, "rst_req_val");
      chk(32'(o_resp_rdy), 32'h0, "rst_resp_rdy");
      chk(32'(o_d_val), 32'h0, "rst_d_val");
      chk(o_req_addr, rst_addr, "rst_pc");
      chk(32'(o_req_opq), 32'h0, "rst_epoch");
      @(negedge clk);
      req_rdy = 1'b0; resp_val = 1'b0; d_rdy = 1'b0;
      rst_n = 1'b1;
      #1;
      chk(32'(o_req_val), 32'h1, "post_rst_req_val");
      chk(o_req_addr, rst_addr, "post_rst_addr");
      chk(32'(o_req_opq), 32'h0, "post_rst_opaque");
      br_idx.delete(); br_off.delete();
      init_model();
      @(posedge clk) #1;
      run_until(3, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
